// File: rtl/anc_pkg.sv
// Shared definitions for the ANC sample scheduler slice.
//   state_t       : scheduler FSM states
//   DEF_W         : default sample width
//   OVR_W, DONE_W : overrun / completed-iteration counter widths
//   sat_inc_ovr   : saturating increment for the overrun counter
package anc_pkg;

  localparam int DEF_W  = 16;
  localparam int OVR_W  = 8;
  localparam int DONE_W = 16;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_OUT = 2'd1,
    ERR      = 2'd2
  } state_t;

  function automatic logic [OVR_W-1:0] sat_inc_ovr(input logic [OVR_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/anc_sample_fifo.sv
// Synchronous FIFO holding packed {e,x,a} sample triples.
//   clk, rst    : clock, synchronous active-high reset
//   flush_i     : empties the FIFO; a same-cycle push is discarded
//   push_i      : write din_i (accepted if not full, or if a pop happens too)
//   pop_i       : advance the head (ignored when empty)
//   din_i       : triple to write
//   dout_o      : current head (valid while !empty_o)
//   full_o      : DEPTH entries held
//   empty_o     : no entries held
//   count_o     : fill level, registered
// DEPTH must be a power of two so the pointers wrap for free.
module anc_sample_fifo #(
  parameter int DW    = 48,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush_i,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic [DW-1:0]            din_i,
  output logic [DW-1:0]            dout_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int AW = $clog2(DEPTH);

  logic [DW-1:0] mem_q [DEPTH];
  logic [AW-1:0] rd_q, wr_q;
  logic [AW:0]   cnt_q;
  logic          do_push, do_pop;

  assign full_o  = (cnt_q == (AW+1)'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign count_o = cnt_q;
  assign dout_o  = mem_q[rd_q];

  // A pop frees the slot in the same edge, so a full FIFO still takes a push.
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  always_ff @(posedge clk) begin
    if (rst || flush_i) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + 1'b1;
      if (do_pop)  rd_q <= rd_q + 1'b1;
      cnt_q <= cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

  // Storage carries no reset; occupancy is tracked by the pointers alone.
  always_ff @(posedge clk) begin
    if (do_push && !flush_i && !rst) mem_q[wr_q] <= din_i;
  end

endmodule

// File: rtl/anc_sample_scheduler.sv
// Feeds buffered sample triples into the ANC controller one iteration at a
// time: issue a sample, wait for the FIR result, then issue the next.
//   clk, rst          : clock, synchronous active-high reset
//   enable            : permits new issues (an iteration in flight always ends)
//   s_valid, s_e/x/a  : incoming sample triple, no backpressure
//   controller_ready  : controller can accept a sample
//   anc_out_valid     : FIR result valid, ends the current iteration
//   in_valid          : one-cycle issue pulse (registered)
//   e_out/x_out/a_out : issued sample, held until the next issue (registered)
//   busy              : iteration in flight (WAIT_OUT)
//   occupancy         : FIFO fill level
//   overrun_cnt       : samples dropped on a full FIFO, saturating
//   done_cnt          : completed iterations, wrapping
//   timeout_err       : sticky, set when a result never arrived
module anc_sample_scheduler
  import anc_pkg::*;
#(
  parameter int W       = DEF_W,
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 1023
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   enable,
  input  logic                   s_valid,
  input  logic signed [W-1:0]    s_e,
  input  logic signed [W-1:0]    s_x,
  input  logic signed [W-1:0]    s_a,
  input  logic                   controller_ready,
  input  logic                   anc_out_valid,
  output logic                   in_valid,
  output logic signed [W-1:0]    e_out,
  output logic signed [W-1:0]    x_out,
  output logic signed [W-1:0]    a_out,
  output logic                   busy,
  output logic [$clog2(DEPTH):0] occupancy,
  output logic [OVR_W-1:0]       overrun_cnt,
  output logic [DONE_W-1:0]      done_cnt,
  output logic                   timeout_err
);

  // The wait counter is 0 in the in_valid cycle and only ever needs to reach
  // TIMEOUT-1: that is the last cycle a result is accepted.
  localparam int             TW    = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0]  TLAST = TW'(TIMEOUT - 1);
  localparam int             DW    = 3 * W;

  state_t              state_q;
  logic [TW-1:0]       wait_q;
  logic                in_valid_q;
  logic [W-1:0]        e_q, x_q, a_q;
  logic [OVR_W-1:0]    ovr_q;
  logic [DONE_W-1:0]   done_q;
  logic                terr_q;

  logic                fifo_full, fifo_empty;
  logic [DW-1:0]       fifo_head;
  logic [$clog2(DEPTH):0] fifo_count;

  logic issue, tmo, push_req, drop;

  assign issue    = (state_q == IDLE) && enable && !fifo_empty && controller_ready;
  // A result on the last allowed cycle wins over the timeout.
  assign tmo      = (state_q == WAIT_OUT) && !anc_out_valid && (wait_q == TLAST);
  // ERR and the flushing edge discard samples without counting them.
  assign push_req = s_valid && (state_q != ERR) && !tmo;
  assign drop     = push_req && fifo_full && !issue;

  anc_sample_fifo #(
    .DW    (DW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .flush_i (tmo),
    .push_i  (push_req),
    .pop_i   (issue),
    .din_i   ({s_e, s_x, s_a}),
    .dout_o  (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      wait_q     <= '0;
      in_valid_q <= 1'b0;
      e_q        <= '0;
      x_q        <= '0;
      a_q        <= '0;
      ovr_q      <= '0;
      done_q     <= '0;
      terr_q     <= 1'b0;
    end else begin
      in_valid_q <= issue;
      if (issue) {e_q, x_q, a_q} <= fifo_head;
      if (drop)  ovr_q <= sat_inc_ovr(ovr_q);

      case (state_q)
        IDLE: begin
          if (issue) begin
            wait_q  <= '0;
            state_q <= WAIT_OUT;
          end
        end
        WAIT_OUT: begin
          if (anc_out_valid) begin
            done_q  <= done_q + 1'b1;
            state_q <= IDLE;
          end else if (tmo) begin
            terr_q  <= 1'b1;
            state_q <= ERR;
          end else begin
            wait_q  <= wait_q + 1'b1;
          end
        end
        ERR: begin
          if (!enable) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_valid    = in_valid_q;
  assign e_out       = e_q;
  assign x_out       = x_q;
  assign a_out       = a_q;
  assign busy        = (state_q == WAIT_OUT);
  assign occupancy   = fifo_count;
  assign overrun_cnt = ovr_q;
  assign done_cnt    = done_q;
  assign timeout_err = terr_q;

endmodule

// File: tb/tb_anc_sample_scheduler.sv
module tb_anc_sample_scheduler;

  localparam int DEPTH = 4;
  localparam int TO_A  = 1023;
  localparam int TO_B  = 8;

  logic clk, rst, en, sv, rdy, aov;
  logic [15:0] se, sx, sa;

  logic        iv   [2];
  logic [15:0] eo   [2];
  logic [15:0] xo   [2];
  logic [15:0] ao   [2];
  logic        bsy  [2];
  logic [2:0]  occ  [2];
  logic [7:0]  ovr  [2];
  logic [15:0] done [2];
  logic        terr [2];

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  bit chk_on = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  anc_sample_scheduler #(.W(16), .DEPTH(DEPTH), .TIMEOUT(TO_A)) u_a (
    .clk(clk), .rst(rst), .enable(en), .s_valid(sv),
    .s_e(se), .s_x(sx), .s_a(sa),
    .controller_ready(rdy), .anc_out_valid(aov),
    .in_valid(iv[0]), .e_out(eo[0]), .x_out(xo[0]), .a_out(ao[0]),
    .busy(bsy[0]), .occupancy(occ[0]), .overrun_cnt(ovr[0]),
    .done_cnt(done[0]), .timeout_err(terr[0]));

  anc_sample_scheduler #(.W(16), .DEPTH(DEPTH), .TIMEOUT(TO_B)) u_b (
    .clk(clk), .rst(rst), .enable(en), .s_valid(sv),
    .s_e(se), .s_x(sx), .s_a(sa),
    .controller_ready(rdy), .anc_out_valid(aov),
    .in_valid(iv[1]), .e_out(eo[1]), .x_out(xo[1]), .a_out(ao[1]),
    .busy(bsy[1]), .occupancy(occ[1]), .overrun_cnt(ovr[1]),
    .done_cnt(done[1]), .timeout_err(terr[1]));

  // ---------------- behavioural model ----------------
  // phase: 0 idle, 1 waiting for result, 2 error
  int          mph   [2];
  int          mwt   [2];
  int          movr  [2];
  int          mdone [2];
  int          mcnt  [2];
  bit          mterr [2];
  bit          minv  [2];
  logic [47:0] mout  [2];
  logic [47:0] mf    [2][16];

  task automatic chk(input string nm, input int m, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s dut%0d cyc=%0d got=%0h exp=%0h", nm, m, cyc, got, exp);
    end
  endtask

  task automatic mstep(input int m, input int T);
    int sz;
    bit full, issue, tmo;
    logic [47:0] head;
    if (rst) begin
      mph[m] = 0; mwt[m] = 0; movr[m] = 0; mdone[m] = 0; mcnt[m] = 0;
      mterr[m] = 0; minv[m] = 0; mout[m] = '0;
      return;
    end
    sz    = mcnt[m];
    full  = (sz == DEPTH);
    issue = (mph[m] == 0) && en && (sz > 0) && rdy;
    // mwt counts cycles since the in_valid cycle; result accepted up to T-1
    tmo   = (mph[m] == 1) && !aov && (mwt[m] == T - 1);
    head  = mf[m][0];
    if (issue) begin
      for (int i = 0; i < 15; i++) mf[m][i] = mf[m][i+1];
      mcnt[m]--;
    end
    if (sv && mph[m] != 2 && !tmo) begin
      if (!full || issue) begin
        mf[m][mcnt[m]] = {se, sx, sa};
        mcnt[m]++;
      end else if (movr[m] < 255) movr[m]++;
    end
    if (tmo) begin
      mcnt[m] = 0;
      mterr[m] = 1;
    end
    minv[m] = issue;
    if (issue) mout[m] = head;
    case (mph[m])
      0: if (issue) begin mph[m] = 1; mwt[m] = 0; end
      1: if (aov) begin mdone[m] = (mdone[m] + 1) % 65536; mph[m] = 0; end
         else if (tmo) mph[m] = 2;
         else mwt[m]++;
      default: if (!en) mph[m] = 0;
    endcase
  endtask

  initial begin
    forever begin
      @(posedge clk);
      mstep(0, TO_A);
      mstep(1, TO_B);
      cyc++;
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (chk_on) begin
        for (int m = 0; m < 2; m++) begin
          chk("in_valid",    m, 32'(iv[m]),   32'(minv[m]));
          chk("e_out",       m, 32'(eo[m]),   32'(mout[m][47:32]));
          chk("x_out",       m, 32'(xo[m]),   32'(mout[m][31:16]));
          chk("a_out",       m, 32'(ao[m]),   32'(mout[m][15:0]));
          chk("busy",        m, 32'(bsy[m]),  32'(mph[m] == 1));
          chk("occupancy",   m, 32'(occ[m]),  32'(mcnt[m]));
          chk("overrun_cnt", m, 32'(ovr[m]),  32'(movr[m]));
          chk("done_cnt",    m, 32'(done[m]), 32'(mdone[m]));
          chk("timeout_err", m, 32'(terr[m]), 32'(mterr[m]));
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic put(input logic [15:0] e, input logic [15:0] x, input logic [15:0] a);
    sv = 1'b1; se = e; sx = x; sa = a;
  endtask

  task automatic reset_pulse();
    rst = 1'b1; sv = 1'b0; aov = 1'b0;
    tick();
    for (int m = 0; m < 2; m++) begin
      chk("rst_in_valid", m, 32'(iv[m]),   32'd0);
      chk("rst_e_out",    m, 32'(eo[m]),   32'd0);
      chk("rst_busy",     m, 32'(bsy[m]),  32'd0);
      chk("rst_occ",      m, 32'(occ[m]),  32'd0);
      chk("rst_ovr",      m, 32'(ovr[m]),  32'd0);
      chk("rst_done",     m, 32'(done[m]), 32'd0);
      chk("rst_terr",     m, 32'(terr[m]), 32'd0);
    end
    rst = 1'b0;
  endtask

  task automatic wait_issue(input int m);
    int n = 0;
    while (!iv[m] && n < 20) begin tick(); n++; end
    if (!iv[m]) begin
      failures++;
      checks++;
      $display("FAIL wait_in_valid dut%0d cyc=%0d got=timeout exp=in_valid", m, cyc);
    end
  endtask

  logic [15:0] exp_e [5];

  initial begin
    rst = 1'b1; en = 1'b0; sv = 1'b0; rdy = 1'b0; aov = 1'b0;
    se = '0; sx = '0; sa = '0;
    ticks(2);
    reset_pulse();
    chk_on = 1'b1;

    // Single sample: s_valid cycle 0 -> in_valid cycle 2, result at cycle 10
    en = 1'b1; rdy = 1'b1;
    put(16'h0100, 16'hFF00, 16'h0010);
    tick(); sv = 1'b0;                               // cycle 1
    tick();                                          // cycle 2
    chk("lit_issue",  0, 32'(iv[0]), 32'd1);
    chk("lit_e",      0, 32'(eo[0]), 32'h0100);
    chk("lit_x",      0, 32'(xo[0]), 32'hFF00);
    chk("lit_a",      0, 32'(ao[0]), 32'h0010);
    tick();                                          // cycle 3
    chk("lit_pulse1", 0, 32'(iv[0]), 32'd0);
    ticks(7);                                        // cycle 10
    chk("lit_busy10", 0, 32'(bsy[0]), 32'd1);
    chk("lit_tmo_b",  1, 32'(terr[1]), 32'd1);
    aov = 1'b1;
    tick(); aov = 1'b0;                              // cycle 11
    chk("lit_done",   0, 32'(done[0]), 32'd1);
    chk("lit_busy11", 0, 32'(bsy[0]), 32'd0);
    chk("lit_done_b", 1, 32'(done[1]), 32'd0);

    // Overrun, then full FIFO with a same-cycle pop and push
    reset_pulse();
    en = 1'b1; rdy = 1'b0;
    for (int i = 0; i < 6; i++) begin
      put(16'(i + 1), 16'(16'h100 + i), 16'(16'h200 + i));
      tick();
    end
    chk("lit_occ_full", 0, 32'(occ[0]), 32'd4);
    chk("lit_ovr2",     0, 32'(ovr[0]), 32'd2);
    rdy = 1'b1;
    put(16'd7, 16'h0107, 16'h0207);
    tick(); sv = 1'b0;
    chk("lit_occ_keep", 0, 32'(occ[0]), 32'd4);
    chk("lit_ovr_keep", 0, 32'(ovr[0]), 32'd2);
    exp_e[0] = 16'd1; exp_e[1] = 16'd2; exp_e[2] = 16'd3;
    exp_e[3] = 16'd4; exp_e[4] = 16'd7;
    for (int k = 0; k < 5; k++) begin
      wait_issue(0);
      chk("lit_order", 0, 32'(eo[0]), 32'(exp_e[k]));
      tick(); aov = 1'b1;
      tick(); aov = 1'b0;
    end
    ticks(2);
    chk("lit_drained", 0, 32'(occ[0]),  32'd0);
    chk("lit_done5",   0, 32'(done[0]), 32'd5);

    // Result on the last accepted cycle (B: issue cycle 2, result cycle 9)
    reset_pulse();
    en = 1'b1; rdy = 1'b1;
    put(16'hAAAA, 16'h0001, 16'h0002);
    tick(); sv = 1'b0;                               // c1
    tick();                                          // c2
    chk("lit_issue_b", 1, 32'(iv[1]), 32'd1);
    ticks(7); aov = 1'b1;                            // c9
    tick(); aov = 1'b0;                              // c10
    chk("lit_edge_done", 1, 32'(done[1]), 32'd1);
    chk("lit_edge_terr", 1, 32'(terr[1]), 32'd0);

    // Timeout on B: issue at c12, error visible c20, FIFO flushed
    put(16'h1111, 16'h0003, 16'h0004);
    tick(); put(16'h2222, 16'h0005, 16'h0006);       // c11
    tick(); sv = 1'b0;                               // c12
    chk("lit_issue2_b", 1, 32'(eo[1]), 32'h1111);
    ticks(7);                                        // c19
    chk("lit_terr19", 1, 32'(terr[1]), 32'd0);
    tick();                                          // c20
    chk("lit_terr20", 1, 32'(terr[1]), 32'd1);
    chk("lit_flush",  1, 32'(occ[1]),  32'd0);
    put(16'h9999, 16'h0007, 16'h0008);               // discarded in ERR
    tick(); sv = 1'b0;                               // c21
    chk("lit_err_occ", 1, 32'(occ[1]), 32'd0);
    chk("lit_err_ovr", 1, 32'(ovr[1]), 32'd0);
    tick(); en = 1'b0;                               // c22
    tick(); en = 1'b1;                               // c23
    put(16'h3333, 16'h0009, 16'h000A);
    tick(); sv = 1'b0;                               // c24
    tick();                                          // c25
    chk("lit_reissue", 1, 32'(eo[1]), 32'h3333);
    chk("lit_sticky",  1, 32'(terr[1]), 32'd1);
    aov = 1'b1;
    tick(); aov = 1'b0;
    ticks(4);

    // Spurious result in IDLE, enable dropped mid-iteration
    reset_pulse();
    en = 1'b1; rdy = 1'b1; aov = 1'b1;               // c0 idle, empty
    tick(); aov = 1'b0;                              // c1
    chk("lit_spurious", 0, 32'(done[0]), 32'd0);
    put(16'h5555, 16'h000B, 16'h000C);
    tick(); sv = 1'b0;                               // c2
    tick();                                          // c3
    tick(); en = 1'b0;                               // c4
    put(16'h6666, 16'h000D, 16'h000E);
    tick(); sv = 1'b0;                               // c5
    tick(); aov = 1'b1;                              // c6
    tick(); aov = 1'b0;                              // c7
    chk("lit_en_done", 0, 32'(done[0]), 32'd1);
    ticks(5);                                        // c12
    chk("lit_no_issue", 0, 32'(iv[0]),  32'd0);
    chk("lit_held_occ", 0, 32'(occ[0]), 32'd1);

    // Reset in the middle of WAIT_OUT
    en = 1'b1;
    ticks(2);
    chk("lit_busy_pre", 0, 32'(bsy[0]), 32'd1);
    put(16'h7777, 16'h000F, 16'h0010);
    tick();
    reset_pulse();

    // Overrun counter saturation
    en = 1'b1; rdy = 1'b0;
    put(16'h0042, 16'h0043, 16'h0044);
    ticks(262);
    sv = 1'b0;
    tick();
    chk("lit_ovr_sat", 0, 32'(ovr[0]), 32'd255);
    ticks(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
